// File: rtl/display_scan_controller.sv
// Eight-digit multiplexed display scanner: per-slot blanking dead time, active-low
// anode/dp drive and frame-synchronous double-buffered digit data.
module display_scan_controller #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en_in,
  input  logic        load,
  output logic        load_ack,
  output logic [2:0]  refreshcounter,
  output logic [7:0]  anode,
  output logic [3:0]  digit_val,
  output logic        dp,
  output logic        frame_start
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  typedef enum logic {BLANK = 1'b0, ON = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] prescaler, prescaler_nxt;
  logic [2:0]    refresh_nxt;
  logic          slot_end, boundary;
  int            presc_nxt_i;

  logic [31:0] stage_digits, act_digits, act_digits_nxt;
  logic [7:0]  stage_dp, act_dp, act_dp_nxt;
  logic [7:0]  stage_en, act_en, act_en_nxt;
  logic        pending, pending_nxt;

  logic        load_ack_nxt, frame_start_nxt, dp_nxt;
  logic [7:0]  anode_nxt;
  logic [3:0]  digit_val_nxt;

  // Every output is computed from next-cycle values so the registered outputs
  // line up with the prescaler/refreshcounter values they describe.
  always_comb begin
    slot_end      = (prescaler == LAST);
    boundary      = slot_end && (refreshcounter == 3'd7);
    prescaler_nxt = slot_end ? '0 : prescaler + PW'(1);
    refresh_nxt   = slot_end ? refreshcounter + 3'd1 : refreshcounter;
    presc_nxt_i   = int'(prescaler_nxt);

    state_nxt = state;
    case (state)
      BLANK:   if (presc_nxt_i >= BLANK_CYCLES) state_nxt = ON;
      ON:      if (presc_nxt_i < BLANK_CYCLES)  state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase

    act_digits_nxt = act_digits;
    act_dp_nxt     = act_dp;
    act_en_nxt     = act_en;
    pending_nxt    = pending;
    if (load) pending_nxt = 1'b1;
    // A load on the boundary cycle itself wins over older staged data.
    if (boundary) begin
      pending_nxt = 1'b0;
      if (load) begin
        act_digits_nxt = digits_in;
        act_dp_nxt     = dp_in;
        act_en_nxt     = digit_en_in;
      end else if (pending) begin
        act_digits_nxt = stage_digits;
        act_dp_nxt     = stage_dp;
        act_en_nxt     = stage_en;
      end
    end

    load_ack_nxt    = boundary && (pending || load);
    frame_start_nxt = boundary;
    digit_val_nxt   = act_digits_nxt[{refresh_nxt, 2'b00} +: 4];
    anode_nxt       = 8'hFF;
    dp_nxt          = 1'b1;
    if (state_nxt == ON && act_en_nxt[refresh_nxt]) begin
      anode_nxt = ~(8'b1 << refresh_nxt);
      dp_nxt    = ~act_dp_nxt[refresh_nxt];
    end
  end

  // State register for the BLANK/ON machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BLANK;
    else        state <= state_nxt;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler      <= '0;
      refreshcounter <= 3'd0;
      stage_digits   <= 32'd0;
      stage_dp       <= 8'd0;
      stage_en       <= 8'd0;
      act_digits     <= 32'd0;
      act_dp         <= 8'd0;
      act_en         <= 8'd0;
      pending        <= 1'b0;
      load_ack       <= 1'b0;
      frame_start    <= 1'b0;
      anode          <= 8'hFF;
      dp             <= 1'b1;
      digit_val      <= 4'd0;
    end else begin
      prescaler      <= prescaler_nxt;
      refreshcounter <= refresh_nxt;
      if (load) begin
        stage_digits <= digits_in;
        stage_dp     <= dp_in;
        stage_en     <= digit_en_in;
      end
      act_digits     <= act_digits_nxt;
      act_dp         <= act_dp_nxt;
      act_en         <= act_en_nxt;
      pending        <= pending_nxt;
      load_ack       <= load_ack_nxt;
      frame_start    <= frame_start_nxt;
      anode          <= anode_nxt;
      dp             <= dp_nxt;
      digit_val      <= digit_val_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized self-checking bench for display_scan_controller with a cycle-count
// based reference model and a few hand-computed checkpoints.
module tb_display_scan_controller;

  localparam int PRESCALE = 8;
  localparam int BLANKC   = 2;
  localparam int FRAME    = 8 * PRESCALE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] digits_in = 32'd0;
  logic [7:0]  dp_in = 8'd0;
  logic [7:0]  digit_en_in = 8'd0;
  logic        load = 1'b0;
  logic        load_ack, dp, frame_start;
  logic [2:0]  refreshcounter;
  logic [7:0]  anode;
  logic [3:0]  digit_val;

  int testsRun = 0;
  int testsFailed = 0;

  display_scan_controller #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANKC)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en_in(digit_en_in), .load(load), .load_ack(load_ack),
    .refreshcounter(refreshcounter), .anode(anode), .digit_val(digit_val),
    .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: mt counts cycles since reset; slot/digit follow by division.
  int          mt;
  logic [31:0] mDigits, sDigits;
  logic [7:0]  mDp, sDp, mEn, sEn;
  bit          mPend, mAck, mFs, isBoundary;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mt = 0; mDigits = 0; mDp = 0; mEn = 0; sDigits = 0; sDp = 0; sEn = 0;
      mPend = 0; mAck = 0; mFs = 0;
    end else begin
      isBoundary = (mt % FRAME) == FRAME - 1;
      mFs  = isBoundary;
      mAck = isBoundary && (mPend || load);
      if (isBoundary) begin
        if (load) begin
          mDigits = digits_in; mDp = dp_in; mEn = digit_en_in;
        end else if (mPend) begin
          mDigits = sDigits; mDp = sDp; mEn = sEn;
        end
        mPend = 0;
      end
      if (load) begin
        sDigits = digits_in; sDp = dp_in; sEn = digit_en_in;
        if (!isBoundary) mPend = 1;
      end
      mt++;
    end
  end

  function automatic logic [17:0] expectedOutputs();
    int p, r;
    bit lit;
    logic [7:0] an;
    logic       d;
    p   = mt % PRESCALE;
    r   = (mt / PRESCALE) % 8;
    lit = (p >= BLANKC) && mEn[r];
    an  = lit ? (8'hFF ^ (8'h01 << r)) : 8'hFF;
    d   = lit ? ~mDp[r] : 1'b1;
    return {mAck, 3'(r), an, mDigits[4*r +: 4], d, mFs};
  endfunction

  function automatic logic [17:0] actualOutputs();
    return {load_ack, refreshcounter, anode, digit_val, dp, frame_start};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit ld, input logic [31:0] d, input logic [7:0] p,
                               input logic [7:0] e);
    load = ld; digits_in = d; dp_in = p; digit_en_in = e;
  endtask

  task automatic pulseLoad(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    applyStimulus(1'b1, d, p, e);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 8'd0, 8'd0);
  endtask

  task automatic waitPhase(input int ph);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((mt % FRAME) != ph && n < 2 * FRAME);
    if ((mt % FRAME) != ph) checkOutput("wait_timeout", 32'(mt % FRAME), 32'(ph));
  endtask

  // Cycle-by-cycle comparison against the model on every falling edge.
  always @(negedge clk) checkOutput("cycle", 32'(actualOutputs()), 32'(expectedOutputs()));

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    checkOutput("reset_values", 32'(actualOutputs()), 32'({1'b0, 3'd0, 8'hFF, 4'h0, 1'b1, 1'b0}));

    // First load right after reset: acknowledged at the first frame wrap, 64 cycles later.
    rst_n = 1'b1;
    pulseLoad(32'h87654321, 8'h00, 8'hFF);
    cnt = 1;
    while (!frame_start && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("first_frame_latency", cnt, 64);
    checkOutput("first_ack", load_ack, 1);
    checkOutput("first_digit", digit_val, 4'h1);
    waitPhase(20);
    checkOutput("digit3_anode", anode, 8'hFB);
    checkOutput("digit3_val", digit_val, 4'h3);
    waitPhase(17);
    checkOutput("digit3_blank", anode, 8'hFF);

    // Upper four digits disabled.
    waitPhase(10);
    pulseLoad(32'h87654321, 8'h00, 8'h0F);
    waitPhase(0);
    waitPhase(44);
    checkOutput("disabled_anode", anode, 8'hFF);
    checkOutput("disabled_val", digit_val, 4'h6);
    waitPhase(20);
    checkOutput("enabled_anode", anode, 8'hFB);

    // Two loads within a frame: last one wins, single acknowledge.
    waitPhase(5);
    pulseLoad(32'h11111111, 8'h00, 8'hFF);
    waitPhase(40);
    pulseLoad(32'h22222222, 8'h00, 8'hFF);
    waitPhase(0);
    checkOutput("last_wins_ack", load_ack, 1);
    checkOutput("last_wins_val", digit_val, 4'h2);
    waitPhase(0);
    checkOutput("no_pending_ack", load_ack, 0);

    // Load exactly on the boundary cycle.
    waitPhase(63);
    pulseLoad(32'hAAAAAAAA, 8'h00, 8'hFF);
    checkOutput("boundary_load_val", digit_val, 4'hA);
    checkOutput("boundary_load_ack", load_ack, 1);

    // Decimal point on digit 1 only, dark during blanking.
    waitPhase(50);
    pulseLoad(32'hAAAAAAAA, 8'h01, 8'hFF);
    waitPhase(1);
    checkOutput("dp_blank", dp, 1);
    waitPhase(2);
    checkOutput("dp_on", dp, 0);
    waitPhase(9);
    checkOutput("dp_digit2", dp, 1);

    // Reset mid-slot with a load pending: pending data is discarded.
    waitPhase(30);
    pulseLoad(32'h12345678, 8'hFF, 8'hFF);
    waitPhase(42);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 32'(actualOutputs()),
                   32'({1'b0, 3'd0, 8'hFF, 4'h0, 1'b1, 1'b0}));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (70) begin
      @(negedge clk);
      if (load_ack) cnt++;
    end
    checkOutput("no_ack_after_reset", cnt, 0);

    // Randomized traffic, biased toward loads landing on the boundary cycle.
    repeat (1500) begin
      bit ld;
      ld = ($urandom_range(0, 15) == 0) ||
           (((mt % FRAME) == FRAME - 1) && ($urandom_range(0, 1) == 1));
      applyStimulus(ld, $urandom, 8'($urandom), 8'($urandom));
      @(negedge clk);
    end
    applyStimulus(1'b0, 32'd0, 8'd0, 8'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
